fp2int: RTL and testbench



---
 rtl/fp2int.sv | 92 +++++++++
 tb/tb_fp2int.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/fp2int.sv
// rtl/fp2int.sv - pipelined float to signed fixed-point converter
// Stage 1 decodes, shifts and rounds to a magnitude; stage 2 applies sign and saturation.
module fp2int #(
   parameter int I_EXP  = 8,
   parameter int I_MNT  = 23,
   parameter int I_DATA = 32,
   parameter int R      = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [I_DATA-1:0] fp_in,
   output logic [I_DATA-1:0] int_out,
   output logic              out_valid
);
   localparam int BIAS = (1 << (I_EXP - 1)) - 1;
   localparam int WW   = I_MNT + 1 + I_DATA;
   localparam logic [WW-1:0]     HALF    = WW'(1) << (I_DATA - 1);
   localparam logic [I_DATA-1:0] POS_MAX = {1'b0, {(I_DATA-1){1'b1}}};
   localparam logic [I_DATA-1:0] NEG_MIN = {1'b1, {(I_DATA-1){1'b0}}};

   logic              sgn;
   logic [I_EXP-1:0]  expo;
   logic [I_MNT-1:0]  mnt;
   logic [I_MNT:0]    sig;
   logic signed [31:0] k;
   logic [31:0]       rk;
   logic [WW-1:0]     mag_w;
   logic              special;

   logic [I_DATA-1:0] mag_d, mag_q;
   logic              ovf_d, ovf_q;
   logic              sign_d, sign_q;
   logic              v1_d, v1_q;
   logic [I_DATA-1:0] int_out_d, int_out_q;
   logic              out_valid_d, out_valid_q;

   always_comb begin
      sgn     = fp_in[I_DATA-1];
      expo    = fp_in[I_DATA-2:I_MNT];
      mnt     = fp_in[I_MNT-1:0];
      sig     = {1'b1, mnt};
      k       = $signed(32'(expo)) - BIAS + R - I_MNT;
      rk      = 32'(-k);
      mag_w   = '0;
      special = (expo == '0) || (&expo);
      ovf_d   = (&expo) && (mnt == '0);
      if (!special) begin
         if (k >= I_DATA)
            ovf_d = 1'b1;
         else if (k >= 0)
            mag_w = WW'(sig) << k;
         // Add half an LSB one position early, then drop it: round to nearest, ties away.
         else if (rk <= 32'(I_MNT + 1))
            mag_w = ((WW'(sig) >> (rk - 32'd1)) + WW'(1)) >> 1;
      end
      if (mag_w > HALF || (mag_w == HALF && !sgn))
         ovf_d = 1'b1;
      mag_d  = mag_w[I_DATA-1:0];
      sign_d = sgn;
      v1_d   = enable;
   end

   always_comb begin
      out_valid_d = v1_q;
      if (ovf_q)
         int_out_d = sign_q ? NEG_MIN : POS_MAX;
      else
         int_out_d = sign_q ? -mag_q : mag_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mag_q       <= '0;
         ovf_q       <= 1'b0;
         sign_q      <= 1'b0;
         v1_q        <= 1'b0;
         int_out_q   <= '0;
         out_valid_q <= 1'b0;
      end else begin
         mag_q       <= mag_d;
         ovf_q       <= ovf_d;
         sign_q      <= sign_d;
         v1_q        <= v1_d;
         int_out_q   <= int_out_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign int_out   = int_out_q;
   assign out_valid = out_valid_q;
endmodule

// File: tb/tb_fp2int.sv
// tb/tb_fp2int.sv - self-checking bench for fp2int
// Directed table plus a random stream checked against a real-arithmetic reference.
module tb_fp2int;
   localparam int N = 240;
   localparam int RST_AT = 120;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [31:0] fp_in;
   logic [31:0] int_out;
   logic        out_valid;

   int errors = 0;
   int checks = 0;

   localparam logic [31:0] DIN [16] = '{
      32'h3F800000, 32'hC0200000, 32'h3B000000, 32'hBB000000,
      32'h3A800000, 32'h00000000, 32'h80000000, 32'h00000001,
      32'h7149F2CA, 32'hFF800000, 32'h7FC00000, 32'hCB000000,
      32'h4B000000, 32'h7F800000, 32'hCB000001, 32'h4AFFFFFF};
   localparam logic [31:0] DOUT [16] = '{
      32'h00000100, 32'hFFFFFD80, 32'h00000001, 32'hFFFFFFFF,
      32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
      32'h7FFFFFFF, 32'h80000000, 32'h00000000, 32'h80000000,
      32'h7FFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h7FFFFF80};

   always #5 clk = ~clk;

   fp2int #(.I_EXP(8), .I_MNT(23), .I_DATA(32), .R(8)) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .fp_in(fp_in),
      .int_out(int_out),
      .out_valid(out_valid)
   );

   function automatic logic [31:0] ref_conv(input logic [31:0] w);
      int     e;
      real    mag;
      real    r;
      longint m;
      e = int'(w[30:23]);
      if (e == 0) return 32'h0;
      if (e == 255) return (w[22:0] != 0) ? 32'h0 : (w[31] ? 32'h80000000 : 32'h7FFFFFFF);
      mag = (1.0 + real'(w[22:0]) / 8388608.0) * (2.0 ** (e - 127)) * 256.0;
      r = $floor(mag + 0.5);
      if (!w[31] && r >= 2147483648.0) return 32'h7FFFFFFF;
      if (w[31] && r > 2147483648.0) return 32'h80000000;
      m = longint'(r);
      if (w[31]) m = -m;
      return m[31:0];
   endfunction

   function automatic logic [31:0] rand_word();
      logic [31:0] w;
      int sel;
      w = $urandom;
      sel = $urandom_range(0, 11);
      if (sel == 0) w[30:23] = 8'd0;
      else if (sel == 1) w[30:23] = 8'd255;
      else if (sel <= 4) w[30:23] = 8'($urandom_range(148, 165));
      else w[30:23] = 8'($urandom_range(100, 150));
      if ($urandom_range(0, 7) == 0) w[22:0] = '0;
      return w;
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      enable = 1'b1;
      fp_in = 32'h3F800000;
      repeat (3) @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_valid: out_valid=%b expected 0", out_valid);
      end
      checks++;
      if (int_out !== 32'h0) begin
         errors++;
         $display("FAIL reset_data: int_out=%h expected 00000000", int_out);
      end
      enable = 1'b0;
      reset = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_directed();
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         enable = 1'b1;
         fp_in = DIN[i];
         @(negedge clk);
         enable = 1'b0;
         fp_in = $urandom;
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL directed_latency[%0d]: out_valid=%b expected 0 one cycle after input", i, out_valid);
         end
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL directed_valid[%0d]: out_valid=%b expected 1", i, out_valid);
         end
         checks++;
         if (int_out !== DOUT[i]) begin
            errors++;
            $display("FAIL directed_data[%0d] in=%h: int_out=%h expected %h", i, DIN[i], int_out, DOUT[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_d [N];
      logic        exp_v [N];
      for (int t = 0; t < N; t++) begin
         @(negedge clk);
         if (t >= 2) begin
            checks++;
            if (out_valid !== exp_v[t-2]) begin
               errors++;
               $display("FAIL stream_valid[%0d]: out_valid=%b expected %b", t - 2, out_valid, exp_v[t-2]);
            end
            if (exp_v[t-2]) begin
               checks++;
               if (int_out !== exp_d[t-2]) begin
                  errors++;
                  $display("FAIL stream_data[%0d]: int_out=%h expected %h", t - 2, int_out, exp_d[t-2]);
               end
            end
         end
         enable = (t < 20) ? (t != 8) : ($urandom_range(0, 4) != 0);
         fp_in = rand_word();
         exp_v[t] = enable;
         exp_d[t] = ref_conv(fp_in);
         if (t == RST_AT) begin
            reset = 1'b1;
            #1;
            checks++;
            if (out_valid !== 1'b0 || int_out !== 32'h0) begin
               errors++;
               $display("FAIL stream_reset: out_valid=%b int_out=%h expected 0 and 00000000", out_valid, int_out);
            end
            exp_v[t-1] = 1'b0;
            exp_v[t] = 1'b0;
         end else if (t == RST_AT + 1) begin
            reset = 1'b0;
         end
      end
      @(negedge clk);
      enable = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      enable = 1'b0;
      fp_in = '0;
      test_reset();
      test_directed();
      test_back_to_back();
      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
